multicycle_control_fsm: RTL and testbench

- Main sequencer for the multicycle ARM calculator core.
- Steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK and drives all datapath mux selects and write enables.
- Holds the NZCV flag register and a latched condition-pass bit, so architectural writes are gated per instruction.
- Sits between the instruction register fields and the shared ALU/register-file/memory datapath.

---
 rtl/multicycle_control_fsm_pkg.sv | 80 ++++++++
 rtl/multicycle_control_fsm_if.sv | 37 +++
 rtl/multicycle_control_fsm_cond_check.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 142 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle ARM control sequencer: state codes,
// instruction field codes, datapath mux selects and the data-processing decode.
package arm_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef struct packed {
    logic [1:0] alu_ctrl;
    logic       no_write;
    logic       arith;     // command produces meaningful C/V
  } dp_dec_t;

  // Unknown commands execute as a harmless ADD with the write suppressed.
  function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
    dp_dec_t d;
    d = '{alu_ctrl: ALU_ADD, no_write: 1'b1, arith: 1'b0};
    case (cmd)
      CMD_ADD: d = '{alu_ctrl: ALU_ADD, no_write: 1'b0, arith: 1'b1};
      CMD_SUB: d = '{alu_ctrl: ALU_SUB, no_write: 1'b0, arith: 1'b1};
      CMD_AND: d = '{alu_ctrl: ALU_AND, no_write: 1'b0, arith: 1'b0};
      CMD_ORR: d = '{alu_ctrl: ALU_ORR, no_write: 1'b0, arith: 1'b0};
      CMD_CMP: d = '{alu_ctrl: ALU_SUB, no_write: 1'b1, arith: 1'b1};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the instruction register fields, the control sequencer and
// the datapath. All signals are plain levels, valid every cycle; no handshake.
interface multicycle_control_fsm_if;

  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;

  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] Flags;
  logic [arm_ctrl_pkg::STATE_BITS-1:0] State;

  modport master (
    input  Op, Funct, Rd, Cond, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, State
  );

  modport slave (
    output Op, Funct, Rd, Cond, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, State
  );

endinterface

// File: rtl/multicycle_control_fsm_cond_check.sv
// ARM condition-code evaluation of an instruction's Cond field against NZCV.
module cond_check
  import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle ARM core: walks each instruction through its
// state path, drives datapath selects/enables and owns the NZCV flag register.
module multicycle_control_fsm
  import arm_ctrl_pkg::*;
#(
    parameter int STATE_W = STATE_BITS
) (
    input  logic                    CLK,
    input  logic                    Reset,
    multicycle_control_fsm_if.master bus
);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;
    logic       cond_ex;
    dp_dec_t    dp;
    logic       rd_is_pc;

    logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b, alu_control;

    assign dp       = dp_decode(bus.Funct[4:1]);
    assign rd_is_pc = (bus.Rd == 4'd15);

    cond_check u_cond_check (
        .cond_i   (bus.Cond),
        .flags_i  (flags_q),
        .cond_ex_o(cond_ex)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        condex_d = condex_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                condex_d = cond_ex;
                case (bus.Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI: begin
                state_d = S_ALUWB;
                // Flags commit as the ALU result is captured, only for S-suffixed passing ops.
                if (condex_q && bus.Funct[0]) begin
                    flags_d[3:2] = bus.ALUFlags[3:2];
                    if (dp.arith) flags_d[1:0] = bus.ALUFlags[1:0];
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_MEMADR: begin
                alu_src_b   = SRCB_IMM;
                alu_control = bus.Funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = condex_q;
                pc_write   = condex_q & rd_is_pc;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = condex_q;
            end
            S_EXECUTER: alu_control = dp.alu_ctrl;
            S_EXECUTEI: begin
                alu_src_b   = SRCB_IMM;
                alu_control = dp.alu_ctrl;
            end
            S_ALUWB: begin
                reg_write = condex_q & ~dp.no_write;
                pc_write  = condex_q & rd_is_pc & ~dp.no_write;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = condex_q;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
    assign bus.Flags      = flags_q;
    assign bus.State      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instructions plus random ones, each
// expanded by an instruction-level model into per-cycle expected control words.
module tb_multicycle_control_fsm;

  localparam int W = 24;

  logic clk;
  logic rst;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [3:0]   m_flags;
  logic [1:0]   cur_op;
  int           n_cmp;
  int           n_fail;

  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  task automatic model_dp(input logic [3:0] cmd, output logic [1:0] aluc,
                          output bit nw, output bit arith);
    aluc = 2'b00; nw = 1'b1; arith = 1'b0;
    if (cmd == 4'b0100) begin aluc = 2'b00; nw = 1'b0; arith = 1'b1; end
    if (cmd == 4'b0010) begin aluc = 2'b01; nw = 1'b0; arith = 1'b1; end
    if (cmd == 4'b0000) begin aluc = 2'b10; nw = 1'b0; end
    if (cmd == 4'b1100) begin aluc = 2'b11; nw = 1'b0; end
    if (cmd == 4'b1010) begin aluc = 2'b01; arith = 1'b1; end
  endtask

  function automatic logic [W-1:0] rec(input logic [3:0] st, input bit pcw, input bit memw,
                                       input bit regw, input bit irw, input bit adr,
                                       input logic [1:0] res, input bit srca,
                                       input logic [1:0] srcb, input logic [1:0] aluc);
    return {st, pcw, memw, regw, irw, adr, res, srca, srcb, aluc,
            cur_op, (cur_op == 2'b01), (cur_op == 2'b10), m_flags};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.State, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
            bus.RegSrc, bus.Flags};
  endfunction

  task automatic compare(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = observed();
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (state %0d vs %0d)",
             tag, obs, exp, obs[W-1 -: 4], exp[W-1 -: 4]);
    end
  endtask

  // driver: apply one instruction and expand it into expected cycles
  task automatic build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                       input logic [3:0] cond, input logic [3:0] alf);
    bit         pass, nw, arith;
    logic [1:0] aluc;
    bus.Op = op; bus.Funct = fn; bus.Rd = rd; bus.Cond = cond; bus.ALUFlags = alf;
    cur_op = op;
    pass = model_cond(cond, m_flags);
    exp_q.push_back(rec(4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00));
    exp_q.push_back(rec(4'd1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00));
    case (op)
      2'b00: begin
        model_dp(fn[4:1], aluc, nw, arith);
        exp_q.push_back(rec(fn[5] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 2'b00, 0,
                            fn[5] ? 2'b01 : 2'b00, aluc));
        if (pass && fn[0]) begin
          m_flags[3:2] = alf[3:2];
          if (arith) m_flags[1:0] = alf[1:0];
        end
        exp_q.push_back(rec(4'd8, pass && !nw && rd == 4'd15, 0, pass && !nw, 0, 0,
                            2'b00, 0, 2'b00, 2'b00));
      end
      2'b01: begin
        exp_q.push_back(rec(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, fn[3] ? 2'b00 : 2'b01));
        if (fn[0]) begin
          exp_q.push_back(rec(4'd3, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00));
          exp_q.push_back(rec(4'd4, pass && rd == 4'd15, 0, pass, 0, 0, 2'b01, 0, 2'b00, 2'b00));
        end else begin
          exp_q.push_back(rec(4'd5, 0, pass, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00));
        end
      end
      2'b10: exp_q.push_back(rec(4'd9, pass, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00));
      default: ;
    endcase
  endtask

  task automatic check_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare(tag, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] cond, input logic [3:0] alf);
    build(op, fn, rd, cond, alf);
    check_cycles(tag, exp_q.size());
  endtask

  function automatic logic [3:0] pick_cmd();
    case ($urandom_range(0, 5))
      0: return 4'b0100;
      1: return 4'b0010;
      2: return 4'b0000;
      3: return 4'b1100;
      4: return 4'b1010;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // stimulus
  initial begin
    logic [1:0] r_op;
    logic [5:0] r_fn;
    logic [3:0] r_rd;
    n_cmp = 0; n_fail = 0;
    m_flags = 4'b0000; cur_op = 2'b00;
    bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0; bus.Cond = 4'b1110; bus.ALUFlags = 4'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    compare("reset_state", rec(4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00));
    #1 rst = 1'b0;

    run_instr("add_reg_s",  2'b00, 6'b001001, 4'd3, 4'b1110, 4'b0100);

    // LDR interrupted by reset while in MEMREAD
    build(2'b01, 6'b011001, 4'd15, 4'b1110, 4'b0000);
    check_cycles("ldr_pre_reset", 3);
    exp_q.delete();
    #2 rst = 1'b1;
    #1 m_flags = 4'b0000;
    compare("reset_in_memread", rec(4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00));
    @(posedge clk); #1;
    compare("reset_held", rec(4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00));
    #2 rst = 1'b0;

    run_instr("cmp_imm_z",  2'b00, 6'b110101, 4'd0, 4'b1110, 4'b0100);
    run_instr("beq_taken",  2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
    run_instr("cmp_imm_nz", 2'b00, 6'b110101, 4'd0, 4'b1110, 4'b0000);
    run_instr("beq_not",    2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
    run_instr("ldr_pc",     2'b01, 6'b011001, 4'd15, 4'b1110, 4'b0000);
    run_instr("str_fail",   2'b01, 6'b011000, 4'd2, 4'b0000, 4'b0000);
    run_instr("undef_op",   2'b11, 6'b111111, 4'd15, 4'b1110, 4'b1111);
    run_instr("nv_add",     2'b00, 6'b001001, 4'd15, 4'b1111, 4'b1111);
    run_instr("sub_s_pc",   2'b00, 6'b000101, 4'd15, 4'b1110, 4'b1011);

    for (int k = 0; k < 400; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_fn = {1'($urandom_range(0, 1)), pick_cmd(), 1'($urandom_range(0, 1))};
      if (r_op != 2'b00) r_fn = 6'($urandom_range(0, 63));
      r_rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      run_instr("random", r_op, r_fn, r_rd, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
